// File: rtl/cw305_crypto_pkg.sv
// -----------------------------------------------------------------------------
// cw305_crypto_pkg
//   Shared definitions for the CW305 crypto-run sequencer.
//   - run_state_e           : sequencer FSM state encoding
//   - CRYPTO_TEXT_WIDTH     : default key / plaintext width (board header value)
//   - CRYPTO_CIPHER_WIDTH   : default ciphertext width (board header value)
//   - CRYPTO_BUSY_WAIT      : default cycles allowed for core busy to rise
//   - CRYPTO_TIMEOUT_CYCLES : default RUN-state timeout (timeout build only)
// -----------------------------------------------------------------------------
package cw305_crypto_pkg;

  localparam int CRYPTO_TEXT_WIDTH     = 128;
  localparam int CRYPTO_CIPHER_WIDTH   = 128;
  localparam int CRYPTO_BUSY_WAIT      = 4;
  localparam int CRYPTO_TIMEOUT_CYCLES = 65535;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_FIRE    = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RUN     = 3'd4,
    ST_CAPTURE = 3'd5
  } run_state_e;

endpackage

// File: rtl/crypto_run_ctrl.sv
// -----------------------------------------------------------------------------
// crypto_run_ctrl
//   Sequencer between the CW305 register block and the crypto core under test.
//   Accepts a start request, latches key/plaintext, fires the core with a
//   one-cycle pulse, follows core busy, captures the ciphertext and frames the
//   power-capture trigger window (high in FIRE, WAIT and RUN).
//   Everything runs on clk (crypt_clk); rst_n is asynchronous, active-low.
//
// Ports
//   clk, rst_n              clock / async active-low reset
//   start_i                 start request (accepted only in IDLE)
//   key_i, textin_i         key / plaintext from the register block
//   ready_o                 high while IDLE
//   done_o                  set on capture, cleared by the next accepted start
//   err_o                   sticky timeout flag, cleared by next accepted start
//   cipher_o                last captured ciphertext
//   run_cnt_o               completed-run counter (wraps, timeouts not counted)
//   core_start_o            one-cycle start pulse to the core
//   core_key_o, core_text_o key / plaintext held stable for the whole run
//   core_busy_i, core_ct_i  core busy and ciphertext
//   trigger_o               scope trigger window
//
// Build option
//   CRYPTO_RUN_TIMEOUT_EN : when defined, RUN is limited to TIMEOUT_CYCLES
//                           cycles; expiry sets err_o and returns to IDLE.
//                           When undefined, RUN waits forever, err_o is 0.
// -----------------------------------------------------------------------------
module crypto_run_ctrl
  import cw305_crypto_pkg::*;
#(
  parameter int TEXT_W         = CRYPTO_TEXT_WIDTH,
  parameter int CIPHER_W       = CRYPTO_CIPHER_WIDTH,
  parameter int BUSY_WAIT      = CRYPTO_BUSY_WAIT,
  parameter int TIMEOUT_CYCLES = CRYPTO_TIMEOUT_CYCLES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic [TEXT_W-1:0]   key_i,
  input  logic [TEXT_W-1:0]   textin_i,
  output logic                ready_o,
  output logic                done_o,
  output logic                err_o,
  output logic [CIPHER_W-1:0] cipher_o,
  output logic [15:0]         run_cnt_o,
  output logic                core_start_o,
  output logic [TEXT_W-1:0]   core_key_o,
  output logic [TEXT_W-1:0]   core_text_o,
  input  logic                core_busy_i,
  input  logic [CIPHER_W-1:0] core_ct_i,
  output logic                trigger_o
);

  // WAIT cycle index on which a still-low busy means "zero-latency core".
  localparam logic [7:0] WAIT_LAST = 8'(BUSY_WAIT - 1);

  run_state_e          state_q, state_d;
  logic [7:0]          wait_cnt_q, wait_cnt_d;
  logic [TEXT_W-1:0]   key_q, key_d;
  logic [TEXT_W-1:0]   text_q, text_d;
  logic [CIPHER_W-1:0] cipher_q, cipher_d;
  logic                done_q, done_d;
  logic [15:0]         run_cnt_q, run_cnt_d;

`ifdef CRYPTO_RUN_TIMEOUT_EN
  // RUN cycle index on which a still-high busy is declared a timeout.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic        err_q, err_d;
  logic [15:0] to_cnt_q, to_cnt_d;
`else
  // No timeout counter in this build; the parameter is kept only so both
  // builds share one parameter list.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_param_unused
  end
`endif

  // ---------------------------------------------------------------------------
  // State / datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= '0;
      key_q      <= '0;
      text_q     <= '0;
      cipher_q   <= '0;
      done_q     <= 1'b0;
      run_cnt_q  <= '0;
`ifdef CRYPTO_RUN_TIMEOUT_EN
      err_q      <= 1'b0;
      to_cnt_q   <= '0;
`endif
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      key_q      <= key_d;
      text_q     <= text_d;
      cipher_q   <= cipher_d;
      done_q     <= done_d;
      run_cnt_q  <= run_cnt_d;
`ifdef CRYPTO_RUN_TIMEOUT_EN
      err_q      <= err_d;
      to_cnt_q   <= to_cnt_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath update
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    // Both cycle counters restart from zero whenever their state is left, so
    // each WAIT / RUN visit is timed from its own first cycle.
    wait_cnt_d = '0;
    key_d      = key_q;
    text_d     = text_q;
    cipher_d   = cipher_q;
    done_d     = done_q;
    run_cnt_d  = run_cnt_q;
`ifdef CRYPTO_RUN_TIMEOUT_EN
    err_d      = err_q;
    to_cnt_d   = '0;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_LOAD;
          key_d   = key_i;
          text_d  = textin_i;
          done_d  = 1'b0;
`ifdef CRYPTO_RUN_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end

      ST_LOAD: state_d = ST_FIRE;

      ST_FIRE: state_d = ST_WAIT;

      ST_WAIT: begin
        // A busy pulse only one cycle long still goes through RUN, which then
        // sees busy low and captures on the following edge.
        if (core_busy_i) begin
          state_d = ST_RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = ST_CAPTURE;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      ST_RUN: begin
        // Busy falling wins over a timeout landing on the same cycle.
        if (!core_busy_i) begin
          state_d = ST_CAPTURE;
        end
`ifdef CRYPTO_RUN_TIMEOUT_EN
        else if (to_cnt_q == TIMEOUT_LAST) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 16'd1;
        end
`endif
      end

      ST_CAPTURE: begin
        state_d   = ST_IDLE;
        cipher_d  = core_ct_i;
        done_d    = 1'b1;
        run_cnt_d = run_cnt_q + 16'd1;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State-decoded outputs; decoded straight from state_q so that an async
  // reset drops the core pulse and trigger immediately.
  // ---------------------------------------------------------------------------
  always_comb begin
    ready_o      = 1'b0;
    core_start_o = 1'b0;
    trigger_o    = 1'b0;
    case (state_q)
      ST_IDLE: ready_o = 1'b1;
      ST_FIRE: begin
        core_start_o = 1'b1;
        trigger_o    = 1'b1;
      end
      ST_WAIT, ST_RUN: trigger_o = 1'b1;
      default: ;
    endcase
  end

  assign done_o      = done_q;
  assign cipher_o    = cipher_q;
  assign run_cnt_o   = run_cnt_q;
  assign core_key_o  = key_q;
  assign core_text_o = text_q;

`ifdef CRYPTO_RUN_TIMEOUT_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
